// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked adder: FSM states, operation encoding
// and the chunk-count helper used to size the index counter.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of chunk cycles per operation; zero for an illegal CHUNK so the
    // elaboration check in the top level reports the error instead.
    function automatic int unsigned chunk_count(input int unsigned width,
                                                input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit ripple chain of full-adder cells.
// Also exposes the carry into the top bit so the caller can form the
// signed-overflow flag on the most significant chunk.
module chunk_add #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             carry_top
);

    logic ripple;

    // Ripple the carry from bit 0 upward, tapping it just before the top cell.
    always_comb begin
        ripple    = carry_in;
        sum       = '0;
        carry_top = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                carry_top = ripple;
            end
            sum[i] = a[i] ^ b[i] ^ ripple;
            ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
        end
        carry_out = ripple;
    end

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits
// per clock with the carry held in a register between chunks.
// Optional flags (overflow, zero) are built when CHUNKED_ADDER_FLAGS_EN is
// defined; otherwise those ports are tied low.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = chunk_count(WIDTH, CHUNK);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0 || WIDTH == 0) begin : g_bad_params
        $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             carry_out_reg;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_carry_in;

    assign a_chunk = a_reg[idx*CHUNK +: CHUNK];
    assign b_chunk = b_reg[idx*CHUNK +: CHUNK];
    assign last    = (idx == LAST);

    chunk_add #(
        .CHUNK(CHUNK)
    ) u_chunk_add (
        .a        (a_chunk),
        .b        (b_chunk),
        .carry_in (carry_reg),
        .sum      (chunk_sum),
        .carry_out(chunk_cout),
        .carry_top(msb_carry_in)
    );

    // Result register with the current chunk merged in; flags see the full word.
    always_comb begin
        sum_next = sum_reg;
        sum_next[idx*CHUNK +: CHUNK] = chunk_sum;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, N chunk cycles in RUN, hold in DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, chunk-by-chunk accumulation and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the borrow input is inverted.
                        a_reg     <= a;
                        b_reg     <= (sub == OP_SUB) ? ~b : b;
                        carry_reg <= carry_in ^ sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_cout;
                    if (last) begin
                        carry_out_reg <= chunk_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHUNKED_ADDER_FLAGS_EN
    logic overflow_reg;
    logic zero_reg;

    // Signed overflow and zero detect, captured on the most significant chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (state == RUN && last) begin
            overflow_reg <= msb_carry_in ^ chunk_cout;
            zero_reg     <= (sum_next == '0);
        end
    end

    assign overflow = overflow_reg;
    assign zero     = zero_reg;
`else
    logic unused_msb_carry;

    assign unused_msb_carry = msb_carry_in;
    assign overflow         = 1'b0;
    assign zero             = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_chunked_adder.sv
// Testbench for chunked_adder: a 32/8 instance and an 8/8 instance checked
// against a plain-arithmetic reference model plus directed corner cases.
module tb_chunked_adder;

`ifdef CHUNKED_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid32 = 1'b0;
    logic        in_valid8 = 1'b0;
    logic [31:0] a_drv = '0;
    logic [31:0] b_drv = '0;
    logic        cin_drv = 1'b0;
    logic        sub_drv = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready32, out_valid32, co32, ov32, z32;
    logic [31:0] sum32;
    logic        in_ready8, out_valid8, co8, ov8, z8;
    logic [7:0]  sum8;

    bit          sel = 1'b0;
    logic        o_in_ready, o_valid, o_co, o_ov, o_z;
    logic [31:0] o_sum;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a_drv), .b(b_drv), .carry_in(cin_drv), .sub(sub_drv),
        .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
        .carry_out(co32), .overflow(ov32), .zero(z32)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .carry_in(cin_drv), .sub(sub_drv),
        .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
        .carry_out(co8), .overflow(ov8), .zero(z8)
    );

    always_comb begin
        if (sel) begin
            o_in_ready = in_ready8;  o_valid = out_valid8; o_sum = {24'h0, sum8};
            o_co = co8; o_ov = ov8; o_z = z8;
        end else begin
            o_in_ready = in_ready32; o_valid = out_valid32; o_sum = sum32;
            o_co = co32; o_ov = ov32; o_z = z32;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on w-bit values, signed range for overflow.
    function automatic void model(input int unsigned w, input logic [31:0] av, bv,
                                  input bit cin, is_sub, output logic [31:0] es,
                                  output bit eco, eov, ez);
        longint lim, ua, ub, sa, sbv, r, sr;
        lim = longint'(1) << w;
        ua  = longint'(av) & (lim - 1);
        ub  = longint'(bv) & (lim - 1);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sbv = (ub >= lim / 2) ? ub - lim : ub;
        if (!is_sub) begin
            r   = ua + ub + longint'(cin);
            sr  = sa + sbv + longint'(cin);
            eco = (r >= lim);
        end else begin
            r   = ua - ub - longint'(cin);
            sr  = sa - sbv - longint'(cin);
            eco = (ua >= ub + longint'(cin));
        end
        es  = 32'(r & (lim - 1));
        eov = FLAGS && ((sr >= lim / 2) || (sr < -(lim / 2)));
        ez  = FLAGS && (es == 0);
    endfunction

    task automatic start_op(input bit s8, input logic [31:0] av, bv, input bit cin, is_sub);
        int unsigned t = 0;
        sel = s8;
        #1;
        while (!o_in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("ready_before_accept", {31'b0, o_in_ready}, 32'd1);
        a_drv = av; b_drv = bv; cin_drv = cin; sub_drv = is_sub;
        in_valid32 = !s8;
        in_valid8  = s8;
        @(negedge clk);
        in_valid32 = 1'b0;
        in_valid8  = 1'b0;
        a_drv   = $urandom;
        b_drv   = $urandom;
        cin_drv = 1'($urandom_range(0, 1));
        sub_drv = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int unsigned lat);
        int unsigned j = 0;
        while (!o_valid && j < 20) begin
            @(negedge clk);
            j++;
        end
        chk("latency", j, lat);
    endtask

    task automatic check_result(input string tag, input logic [31:0] es, input bit eco, eov, ez);
        chk({tag, "_sum"}, o_sum, es);
        chk({tag, "_carry_out"}, {31'b0, o_co}, {31'b0, eco});
        chk({tag, "_overflow"}, {31'b0, o_ov}, {31'b0, eov});
        chk({tag, "_zero"}, {31'b0, o_z}, {31'b0, ez});
    endtask

    task automatic finish_hs();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_handshake", {31'b0, o_valid}, 32'd0);
        chk("ready_after_handshake", {31'b0, o_in_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input bit s8, input logic [31:0] av, bv,
                         input bit cin, is_sub, input logic [31:0] es,
                         input bit eco, eov, ez);
        start_op(s8, av, bv, cin, is_sub);
        wait_done(s8 ? 1 : 4);
        check_result(tag, es, eco, eov, ez);
        finish_hs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb, es;
        bit rc, rs, eco, eov, ez;

        // Reset values on both instances.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
            chk("rst_out_valid", {31'b0, o_valid}, 32'd0);
            chk("rst_sum", o_sum, 32'd0);
            chk("rst_flags", {29'b0, o_co, o_ov, o_z}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, 32/8.
        do_op("wrap", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, FLAGS);
        do_op("sub_neg", 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_pos", 1'b0, 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
        do_op("sgn_ovf", 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, FLAGS, 1'b0);

        // Directed corner cases, 8/8 (single RUN cycle).
        do_op("n1_ovf", 1'b1, 32'h66, 32'h77, 1'b0, 1'b0, 32'hDD, 1'b0, FLAGS, 1'b0);
        do_op("n1_zero", 1'b1, 32'h80, 32'h80, 1'b0, 1'b0, 32'h0, 1'b1, FLAGS, FLAGS);

        // Backpressure: result holds and new operands are refused in DONE.
        model(32, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, es, eco, eov, ez);
        start_op(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
        wait_done(4);
        for (int k = 0; k < 5; k++) begin
            in_valid32 = (k % 2 == 0);
            a_drv = $urandom;
            b_drv = $urandom;
            @(negedge clk);
            chk("bp_valid", {31'b0, o_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, o_in_ready}, 32'd0);
            check_result("bp", es, eco, eov, ez);
        end
        in_valid32 = 1'b0;
        finish_hs();
        repeat (2) begin
            @(negedge clk);
            chk("bp_no_new_op", {30'b0, o_valid, o_in_ready}, 32'd1);
        end

        // Reset while chunk 2 is being added.
        start_op(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("midrst_sum", o_sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 6 == 0) ? ra : 32'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(32, ra, rb, rc, rs, es, eco, eov, ez);
            do_op("rand32", 1'b0, ra, rb, rc, rs, es, eco, eov, ez);
        end
        for (int i = 0; i < 12; i++) begin
            ra = 32'($urandom_range(0, 255));
            rb = 32'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(8, ra, rb, rc, rs, es, eco, eov, ez);
            do_op("rand8", 1'b1, ra, rb, rc, rs, es, eco, eov, ez);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
